// File: rtl/count_monitor.sv
// count_monitor: receive-side checker for a free-running up-counter bus.
// Each valid sample must equal the previous sample + 1 (mod 2^WIDTH).
// Reports lock status, one-cycle error pulses and a saturating error tally.
// Optional stuck-value detection is built when COUNT_MON_STUCK_EN is defined;
// otherwise the stuck port is tied low.
module count_monitor #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_W     = 8,
  parameter int STUCK_LIM = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_count,
  output logic             stuck,
  input  logic             vdd,
  input  logic             gnd
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [GOOD_W-1:0] good, good_nxt;
  logic              locked_nxt;
  logic              err_pulse_nxt;
  logic [ERR_W-1:0]  err_count_nxt;
  logic [WIDTH-1:0]  last_count_nxt;
  logic [WIDTH-1:0]  expected;
  logic              match;

  // Power pins carry no logic; fold them (and the stuck limit) into a sink.
  logic unused_pins;
  assign unused_pins = vdd ^ gnd ^ (STUCK_LIM == 0);

  // Error tally holds at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Wrap from all-ones to zero is a legal increment.
  assign expected = last_count + WIDTH'(1);
  assign match    = (count_in == expected);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      good       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      last_count <= '0;
    end else begin
      state      <= state_nxt;
      good       <= good_nxt;
      locked     <= locked_nxt;
      err_pulse  <= err_pulse_nxt;
      err_count  <= err_count_nxt;
      last_count <= last_count_nxt;
    end
  end

  // Next-state and next-output decode; clear outranks a coincident sample.
  always_comb begin
    state_nxt      = state;
    good_nxt       = good;
    locked_nxt     = locked;
    err_pulse_nxt  = 1'b0;
    err_count_nxt  = err_count;
    last_count_nxt = last_count;
    if (clear) begin
      state_nxt     = IDLE;
      good_nxt      = '0;
      locked_nxt    = 1'b0;
      err_count_nxt = '0;
    end else if (valid_in) begin
      // Every accepted sample becomes the new reference, good or bad.
      last_count_nxt = count_in;
      case (state)
        IDLE: begin
          state_nxt = ACQ;
          good_nxt  = '0;
        end
        ACQ: begin
          if (match) begin
            good_nxt = good + GOOD_W'(1);
            if (good == GOOD_W'(LOCK_CNT - 1)) begin
              state_nxt  = LOCK;
              locked_nxt = 1'b1;
            end
          end else begin
            good_nxt = '0;
          end
        end
        LOCK: begin
          if (!match) begin
            state_nxt     = ACQ;
            good_nxt      = '0;
            locked_nxt    = 1'b0;
            err_pulse_nxt = 1'b1;
            err_count_nxt = sat_inc(err_count);
          end
        end
        default: begin
          state_nxt  = IDLE;
          good_nxt   = '0;
          locked_nxt = 1'b0;
        end
      endcase
    end
  end

`ifdef COUNT_MON_STUCK_EN
  localparam int REP_W = $clog2(STUCK_LIM + 1);

  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_inc;

  // Repeat count saturates at the limit so stuck stays asserted.
  assign rep_inc = (rep == REP_W'(STUCK_LIM)) ? rep : rep + REP_W'(1);

  // Track consecutive repeats of the last accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep   <= '0;
      stuck <= 1'b0;
    end else if (clear) begin
      rep   <= '0;
      stuck <= 1'b0;
    end else if (valid_in) begin
      if (count_in == last_count) begin
        rep   <= rep_inc;
        stuck <= (rep_inc == REP_W'(STUCK_LIM));
      end else begin
        rep   <= '0;
        stuck <= 1'b0;
      end
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor. Three instances share the
// stimulus: default parameters, ERR_W=2 (saturation) and LOCK_CNT=1.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       clear = 1'b0;

  logic       locked, err_pulse, stuck;
  logic [7:0] err_count;
  logic [3:0] last_count;

  logic       locked_s, err_pulse_s, stuck_s;
  logic [1:0] err_count_s;
  logic [3:0] last_count_s;

  logic       locked_l, err_pulse_l, stuck_l;
  logic [7:0] err_count_l;
  logic [3:0] last_count_l;

  int tests = 0;
  int fails = 0;

`ifdef COUNT_MON_STUCK_EN
  localparam bit STUCK_ON = 1'b1;
`else
  localparam bit STUCK_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  count_monitor dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .count_in(count_in),
    .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .last_count(last_count), .stuck(stuck),
    .vdd(1'b1), .gnd(1'b0)
  );

  count_monitor #(.ERR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .count_in(count_in),
    .clear(clear), .locked(locked_s), .err_pulse(err_pulse_s),
    .err_count(err_count_s), .last_count(last_count_s), .stuck(stuck_s),
    .vdd(1'b1), .gnd(1'b0)
  );

  count_monitor #(.LOCK_CNT(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .count_in(count_in),
    .clear(clear), .locked(locked_l), .err_pulse(err_pulse_l),
    .err_count(err_count_l), .last_count(last_count_l), .stuck(stuck_l),
    .vdd(1'b1), .gnd(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    valid_in = v;
    count_in = c;
    clear    = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_last", 32'(last_count), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    rst_n = 1'b1;

    // 1: acquire lock on 0,1,2,3
    step(1'b1, 4'd0, 1'b0);
    check("first_locked", 32'(locked), 32'd0);
    check("l1_first_locked", 32'(locked_l), 32'd0);
    step(1'b1, 4'd1, 1'b0);
    check("l1_locked", 32'(locked_l), 32'd1);
    check("s1_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd2, 1'b0);
    check("s2_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd3, 1'b0);
    check("s3_locked", 32'(locked), 32'd1);
    check("s3_err_count", 32'(err_count), 32'd0);
    check("s3_last", 32'(last_count), 32'd3);

    // Idle cycle holds everything
    step(1'b0, 4'd9, 1'b0);
    check("idle_locked", 32'(locked), 32'd1);
    check("idle_last", 32'(last_count), 32'd3);

    // 2: run through the wrap F->0 and stop at 5
    for (int i = 4; i <= 21; i++) begin
      step(1'b1, 4'(i % 16), 1'b0);
      check("wrap_locked", 32'(locked), 32'd1);
      check("wrap_err_pulse", 32'(err_pulse), 32'd0);
    end
    check("wrap_last", 32'(last_count), 32'd5);

    // 3: error at 9 then relock on A,B,C
    step(1'b1, 4'd9, 1'b0);
    check("err_pulse", 32'(err_pulse), 32'd1);
    check("err_count1", 32'(err_count), 32'd1);
    check("err_locked", 32'(locked), 32'd0);
    check("err_last", 32'(last_count), 32'd9);
    step(1'b0, 4'd0, 1'b0);
    check("pulse_one_cycle", 32'(err_pulse), 32'd0);
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'hB, 1'b0);
    check("relock_B", 32'(locked), 32'd0);
    step(1'b1, 4'hC, 1'b0);
    check("relock_C", 32'(locked), 32'd1);

    // 4: four more errors, relocking each time
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'd0, 1'b0);
      check("loop_err_pulse", 32'(err_pulse), 32'd1);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      check("loop_relock", 32'(locked), 32'd1);
    end
    check("err_count5", 32'(err_count), 32'd5);
    check("sat_err_count", 32'(err_count_s), 32'd3);

    // 5: clear with coincident sample 7 (dropped)
    step(1'b1, 4'd7, 1'b1);
    check("clr_locked", 32'(locked), 32'd0);
    check("clr_err_count", 32'(err_count), 32'd0);
    check("clr_last", 32'(last_count), 32'd3);
    check("clr_err_pulse", 32'(err_pulse), 32'd0);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    check("clr_idle_6", 32'(locked), 32'd0);
    step(1'b1, 4'd7, 1'b0);
    check("clr_relock_7", 32'(locked), 32'd1);
    step(1'b1, 4'd0, 1'b0);
    check("pre_rst_err", 32'(err_count), 32'd1);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    check("pre_rst_locked", 32'(locked), 32'd1);

    // Async reset mid-LOCK
    rst_n = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_last", 32'(last_count), 32'd0);
    check("arst_err_pulse", 32'(err_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    check("post_rst_7", 32'(locked), 32'd0);
    step(1'b1, 4'd8, 1'b0);
    check("post_rst_8", 32'(locked), 32'd1);

    // 6: repeat 8 four times, then 9
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'd8, 1'b0);
      check("rep_err_pulse", 32'(err_pulse), (i == 0) ? 32'd1 : 32'd0);
      check("rep_stuck", 32'(stuck), (STUCK_ON && i == 3) ? 32'd1 : 32'd0);
    end
    step(1'b1, 4'd9, 1'b0);
    check("unstuck", 32'(stuck), 32'd0);
    check("unstuck_last", 32'(last_count), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
